uart_rx_ctrl: RTL and testbench

//  Sequencer and buffer for the RS232 receive core. Generates the mid-bit bps strobe the core samples on

---
 rtl/uart_pkg.sv | 12 +
 rtl/uart_rx_fifo.sv | 47 ++++
 rtl/uart_rx_ctrl.sv | 66 ++++++
 tb/tb_uart_rx_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants and the baud divider helper.
package uart_pkg;
    localparam int UART_DATA_W    = 8;
    localparam int CLK_HZ_DEFAULT = 50_000_000;
    localparam int BAUD_DEFAULT   = 115_200;

    function automatic int baud_div(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

    localparam int CLK_DIV_DEFAULT = baud_div(CLK_HZ_DEFAULT, BAUD_DEFAULT);
endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word fall-through FIFO; a push into a full FIFO is accepted only alongside a pop.
module uart_rx_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     rd_en,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_pop, do_push;

    always_comb begin
        empty    = wr_ptr_q == rd_ptr_q;
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        count    = wr_ptr_q - rd_ptr_q;
        do_pop   = rd_en && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        rd_data  = mem_q[rd_ptr_q[AW-1:0]];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // When full, the write slot equals the head being popped; the old head is read before the edge.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end
endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: mid-bit baud strobe for the RX core, rxReady edge capture into a FIFO, sticky overrun.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEFAULT,
    parameter int DEPTH   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     startBPS,
    output logic                     bps,
    input  logic [UART_DATA_W-1:0]   rxData,
    input  logic                     rxReady,
    input  logic                     rdEn,
    output logic [UART_DATA_W-1:0]   rdData,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overrun,
    input  logic                     clrOverrun
);
    logic [15:0] cnt_q, cnt_d;
    logic        bps_q, bps_d;
    logic        rdy_q, rdy_d;
    logic        overrun_q, overrun_d;
    logic        push, drop;

    always_comb begin
        cnt_d     = !startBPS ? 16'd0 : (cnt_q == 16'(CLK_DIV - 1)) ? 16'd0 : cnt_q + 16'd1;
        bps_d     = startBPS && (cnt_q == 16'(CLK_DIV / 2));
        rdy_d     = rxReady;
        push      = rxReady && !rdy_q;
        // full implies non-empty, so rdEn alone means the pop frees a slot this cycle
        drop      = push && full && !rdEn;
        overrun_d = drop || (overrun_q && !clrOverrun);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            bps_q     <= 1'b0;
            rdy_q     <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            bps_q     <= bps_d;
            rdy_q     <= rdy_d;
            overrun_q <= overrun_d;
        end
    end

    assign bps     = bps_q;
    assign overrun = overrun_q;

    uart_rx_fifo #(.DEPTH(DEPTH), .WIDTH(UART_DATA_W)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .rd_en   (rdEn),
        .wr_data (rxData),
        .rd_data (rdData),
        .empty   (empty),
        .full    (full),
        .count   (count)
    );
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: queue-based reference model checked every cycle, plus directed literal checks.
module tb_uart_rx_ctrl;
    localparam int CLK_DIV = 8;
    localparam int DEPTH   = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       startBPS = 1'b0, rxReady = 1'b0, rdEn = 1'b0, clrOverrun = 1'b0;
    logic [7:0] rxData = 8'h00;
    logic       bps, empty, full, overrun;
    logic [7:0] rdData;
    logic [2:0] count;

    int n_cmp = 0;
    int n_bad = 0;

    uart_rx_ctrl #(.CLK_DIV(CLK_DIV), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .startBPS   (startBPS),
        .bps        (bps),
        .rxData     (rxData),
        .rxReady    (rxReady),
        .rdEn       (rdEn),
        .rdData     (rdData),
        .empty      (empty),
        .full       (full),
        .count      (count),
        .overrun    (overrun),
        .clrOverrun (clrOverrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: bytes as a queue, strobes from the length of the current startBPS run.
    logic [7:0] mq[$];
    bit         m_prev, m_ovr, m_bps, m_push, m_pop;
    int         run_len;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            m_prev  = 0;
            m_ovr   = 0;
            m_bps   = 0;
            run_len = 0;
        end else begin
            m_push  = rxReady && !m_prev;
            m_pop   = rdEn && mq.size() > 0;
            m_prev  = rxReady;
            run_len = startBPS ? run_len + 1 : 0;
            m_bps   = startBPS && run_len >= CLK_DIV / 2 + 1 && (run_len - (CLK_DIV / 2 + 1)) % CLK_DIV == 0;
            if (clrOverrun) m_ovr = 0;
            if (m_pop) void'(mq.pop_front());
            if (m_push) begin
                if (mq.size() < DEPTH) mq.push_back(rxData);
                else m_ovr = 1;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        chk("bps", int'(bps), int'(m_bps));
        chk("empty", int'(empty), int'(mq.size() == 0));
        chk("full", int'(full), int'(mq.size() == DEPTH));
        chk("count", int'(count), mq.size());
        chk("overrun", int'(overrun), int'(m_ovr));
        if (mq.size() > 0) chk("rdData", int'(rdData), int'(mq[0]));
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [7:0] v, input logic pop, input logic clr);
        rxData = v; rxReady = 1'b1; rdEn = pop; clrOverrun = clr;
        tick(1);
        rxReady = 1'b0; rdEn = 1'b0; clrOverrun = 1'b0;
        tick(1);
    endtask

    task automatic pop_one();
        rdEn = 1'b1;
        tick(1);
        rdEn = 1'b0;
    endtask

    initial begin
        tick(2);
        chk("rst_empty", int'(empty), 1);
        chk("rst_count", int'(count), 0);
        rst = 1'b0;
        tick(2);
        // strobes at 5,13,21,29,37 after rise
        startBPS = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            tick(1);
            chk("t1_bps", int'(bps), int'(i == 5 || i == 13 || i == 21 || i == 29 || i == 37));
        end
        startBPS = 1'b0;
        tick(3);
        // drop at counter 2, then re-raise
        startBPS = 1'b1;
        tick(2);
        startBPS = 1'b0;
        tick(3);
        chk("t2_low", int'(bps), 0);
        startBPS = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick(1);
            chk("t2_bps", int'(bps), int'(i == 5));
        end
        startBPS = 1'b0;
        tick(2);
        // long rxReady -> single push
        rxData = 8'hA5; rxReady = 1'b1;
        tick(1);
        chk("t3_data", int'(rdData), 8'hA5);
        tick(9);
        rxReady = 1'b0;
        tick(1);
        chk("t3_count", int'(count), 1);
        pop_one();
        chk("t3_empty", int'(empty), 1);
        pop_one();
        chk("t3_empty_pop", int'(count), 0);
        // overflow
        for (int v = 1; v <= 5; v++) begin
            send(8'(v), 1'b0, 1'b0);
            if (v == 4) chk("t4_full", int'(full), 1);
        end
        chk("t4_ovr", int'(overrun), 1);
        chk("t4_count", int'(count), 4);
        for (int v = 1; v <= 4; v++) begin
            chk("t4_pop", int'(rdData), v);
            pop_one();
        end
        chk("t4_empty", int'(empty), 1);
        clrOverrun = 1'b1;
        tick(1);
        clrOverrun = 1'b0;
        chk("t4_clr", int'(overrun), 0);
        // push+pop while full
        for (int v = 16; v < 20; v++) send(8'(v), 1'b0, 1'b0);
        send(8'h77, 1'b1, 1'b0);
        chk("t5_ovr", int'(overrun), 0);
        chk("t5_count", int'(count), 4);
        for (int v = 0; v < 4; v++) begin
            chk("t5_pop", int'(rdData), v == 3 ? 8'h77 : 17 + v);
            pop_one();
        end
        // drop and clear in the same cycle keeps overrun set
        for (int v = 32; v < 36; v++) send(8'(v), 1'b0, 1'b0);
        send(8'h99, 1'b0, 1'b1);
        chk("t5_drop_clr", int'(overrun), 1);
        pop_one();
        chk("t6_count3", int'(count), 3);
        // reset mid-frame
        startBPS = 1'b1;
        tick(5);
        chk("t6_bps_pre", int'(bps), 1);
        rst = 1'b1;
        #1;
        chk("t6_bps", int'(bps), 0);
        chk("t6_count", int'(count), 0);
        chk("t6_empty", int'(empty), 1);
        chk("t6_ovr", int'(overrun), 0);
        tick(2);
        rst = 1'b0;
        tick(2);
        startBPS = 1'b0;
        send(8'h3C, 1'b0, 1'b0);
        chk("t6_data", int'(rdData), 8'h3C);
        pop_one();
        chk("t6_end_empty", int'(empty), 1);
        tick(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
